mixer_round_robin_sequencer: RTL



---
 rtl/mixer_round_robin_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mixer_round_robin_sequencer.sv
// Round-robin arbiter and FILL -> MIX -> FLUSH sequencer sharing one mixer
// between N_REQ chambers; all valve/pump outputs are registered.
module mixer_round_robin_sequencer #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned FILL_CYCLES  = 16,
    parameter int unsigned MIX_CYCLES   = 64,
    parameter int unsigned FLUSH_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             abort,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] inlet_valve,
    output logic             mix_pump,
    output logic             flush_valve,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_MIX   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIX_LOAD   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PTR_W-1:0] last_ptr, ptr_nxt;
    logic             ab_flag, ab_flag_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [PTR_W-1:0] sel;

    logic [N_REQ-1:0] inlet_nxt;
    logic             mix_nxt, flush_nxt, busy_nxt, done_nxt, aborted_nxt;

    // First requester strictly after last, wrapping modulo N_REQ.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [PTR_W-1:0] last);
        logic [PTR_W-1:0] pick;
        logic [PTR_W-1:0] cand;
        logic             hit;
        int unsigned      idx;
        pick = '0;
        hit  = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx  = (32'(last) + i) % N_REQ;
            cand = PTR_W'(idx);
            if (!hit && r[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
        return pick;
    endfunction

    always_comb begin
        sel = rr_pick(req, last_ptr);
    end

    // Next-state, counter, pointer and grant logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ptr_nxt     = last_ptr;
        ab_flag_nxt = ab_flag;
        grant_nxt   = grant;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    ptr_nxt   = sel;
                    grant_nxt = N_REQ'(1) << sel;
                    cnt_nxt   = FILL_LOAD;
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_nxt   = S_FLUSH;
                    cnt_nxt     = FLUSH_LOAD;
                    ab_flag_nxt = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = S_MIX;
                    cnt_nxt   = MIX_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_MIX: begin
                if (abort) begin
                    state_nxt   = S_FLUSH;
                    cnt_nxt     = FLUSH_LOAD;
                    ab_flag_nxt = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt   = S_IDLE;
                grant_nxt   = '0;
                ab_flag_nxt = 1'b0;
            end
            default: begin
                state_nxt   = S_IDLE;
                cnt_nxt     = '0;
                grant_nxt   = '0;
                ab_flag_nxt = 1'b0;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs change on the same edge as state.
    always_comb begin
        inlet_nxt   = (state_nxt == S_FILL) ? grant_nxt : '0;
        mix_nxt     = (state_nxt == S_MIX);
        flush_nxt   = (state_nxt == S_FLUSH);
        busy_nxt    = (state_nxt != S_IDLE);
        done_nxt    = (state_nxt == S_DONE);
        aborted_nxt = (state_nxt == S_DONE) && ab_flag_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last_ptr <= PTR_W'(N_REQ - 1);
            ab_flag  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last_ptr <= ptr_nxt;
            ab_flag  <= ab_flag_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            inlet_valve <= '0;
            mix_pump    <= 1'b0;
            flush_valve <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            grant       <= grant_nxt;
            inlet_valve <= inlet_nxt;
            mix_pump    <= mix_nxt;
            flush_valve <= flush_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            aborted     <= aborted_nxt;
        end
    end

endmodule
